// File: rtl/chirp_pkg.sv
// Shared types, field codes and helpers for the chirp sequencer and its profile table.
package chirp_pkg;

    localparam int NPROF   = 4;
    localparam int MIN_GAP = 3;

    typedef enum logic [1:0] {
        FIELD_FREQ  = 2'd0,
        FIELD_DFREQ = 2'd1,
        FIELD_DRATE = 2'd2,
        FIELD_LEN   = 2'd3
    } cfg_field_e;

    typedef struct packed {
        logic [47:0] freq;
        logic [47:0] delta_freq;
        logic [31:0] delta_rate;
        logic [31:0] len;
    } chirp_prof_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        ACTIVE = 2'd2,
        GAP    = 2'd3
    } chirp_state_e;

    // A zero-length profile still produces a single gate cycle.
    function automatic logic [31:0] pulse_len(input logic [31:0] len);
        return (len == 32'd0) ? 32'd1 : len;
    endfunction

    // GAP length for one interval: max(period, L+1+min_gap) - L - 1, in 33 bits so nothing wraps.
    function automatic logic [32:0] gap_cycles(input logic [31:0] period,
                                               input logic [31:0] plen,
                                               input int unsigned min_gap);
        logic [32:0] need;
        logic [32:0] ivl;
        need = {1'b0, plen} + 33'd1 + 33'(min_gap);
        ivl  = ({1'b0, period} > need) ? {1'b0, period} : need;
        return ivl - {1'b0, plen} - 33'd1;
    endfunction

endpackage

// File: rtl/chirp_profile_ram.sv
// Register-based chirp profile table: one field written per strobe, combinational read.
module chirp_profile_ram #(
    parameter int NPROF = chirp_pkg::NPROF,
    parameter int IW    = (NPROF > 1) ? $clog2(NPROF) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [IW-1:0]         wr_sel,
    input  logic [1:0]            wr_field,
    input  logic [47:0]           wr_data,
    input  logic [IW-1:0]         rd_sel,
    output chirp_pkg::chirp_prof_t rd_prof
);
    import chirp_pkg::*;

    chirp_prof_t mem_q [NPROF];
    chirp_prof_t mem_d [NPROF];

    // Merge the addressed field of the selected entry into the next table image.
    always_comb begin
        mem_d = mem_q;
        if (we) begin
            case (wr_field)
                FIELD_FREQ:  mem_d[wr_sel].freq       = wr_data;
                FIELD_DFREQ: mem_d[wr_sel].delta_freq = wr_data;
                FIELD_DRATE: mem_d[wr_sel].delta_rate = wr_data[31:0];
                default:     mem_d[wr_sel].len        = wr_data[31:0];
            endcase
        end
    end

    // Table storage; reset wipes every entry so a fresh run starts from zeros.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NPROF; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rd_prof = mem_q[rd_sel];

endmodule

// File: rtl/chirp_sequencer.sv
// Chirp sequencer: steps through profile table entries, presenting each profile to the DDS
// and gating it with dds_start for the profile length at a fixed repetition interval.
module chirp_sequencer #(
    parameter int NPROF   = chirp_pkg::NPROF,
    parameter int MIN_GAP = chirp_pkg::MIN_GAP,
    parameter int IW      = (NPROF > 1) ? $clog2(NPROF) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_we,
    input  logic [IW-1:0] cfg_sel,
    input  logic [1:0]    cfg_field,
    input  logic [47:0]   cfg_wdata,
    input  logic          run,
    input  logic [IW-1:0] num_prof_m1,
    input  logic [31:0]   period,
    output logic [47:0]   dds_freq,
    output logic [47:0]   dds_delta_freq,
    output logic [31:0]   dds_delta_rate,
    output logic          dds_start,
    output logic [IW-1:0] prof_idx,
    output logic          pulse_done,
    output logic          busy
);
    import chirp_pkg::*;

    chirp_state_e state_q, state_d;
    logic [IW-1:0] prof_idx_q, prof_idx_d;
    logic [IW-1:0] last_idx_q, last_idx_d;
    logic [IW-1:0] adv_idx;
    logic [32:0]   cnt_q, cnt_d;
    logic [32:0]   gap_q, gap_d;
    logic [31:0]   len_q, len_d;
    logic [47:0]   freq_q, freq_d;
    logic [47:0]   dfreq_q, dfreq_d;
    logic [31:0]   drate_q, drate_d;
    logic          dds_start_q, dds_start_d;
    logic          pulse_done_q, pulse_done_d;
    logic          busy_q, busy_d;
    logic          load_en;
    chirp_prof_t   rd_prof;

    chirp_profile_ram #(.NPROF(NPROF), .IW(IW)) u_ram (
        .clk      (clk),
        .rst      (rst),
        .we       (cfg_we),
        .wr_sel   (cfg_sel),
        .wr_field (cfg_field),
        .wr_data  (cfg_wdata),
        .rd_sel   (prof_idx_d),
        .rd_prof  (rd_prof)
    );

    // Sequencing decisions: next state, profile index, cycle counter and gate/strobe levels.
    always_comb begin
        state_d      = state_q;
        prof_idx_d   = prof_idx_q;
        last_idx_d   = last_idx_q;
        cnt_d        = cnt_q;
        gap_d        = gap_q;
        dds_start_d  = 1'b0;
        pulse_done_d = 1'b0;
        load_en      = 1'b0;
        adv_idx      = (prof_idx_q >= last_idx_q) ? '0 : prof_idx_q + 1'b1;
        case (state_q)
            IDLE: begin
                if (run) begin
                    state_d    = LOAD;
                    prof_idx_d = '0;
                    load_en    = 1'b1;
                end
            end
            LOAD: begin
                if (!run) begin
                    state_d = IDLE;
                end else begin
                    state_d      = ACTIVE;
                    last_idx_d   = num_prof_m1;
                    gap_d        = gap_cycles(period, len_q, MIN_GAP);
                    cnt_d        = 33'd1;
                    dds_start_d  = 1'b1;
                    pulse_done_d = (len_q == 32'd1);
                end
            end
            ACTIVE: begin
                if (cnt_q == {1'b0, len_q}) begin
                    cnt_d = 33'd1;
                    if (!run) begin
                        state_d = IDLE;
                    end else if (gap_q == 33'd0) begin
                        state_d    = LOAD;
                        prof_idx_d = adv_idx;
                        load_en    = 1'b1;
                    end else begin
                        state_d = GAP;
                    end
                end else begin
                    cnt_d        = cnt_q + 33'd1;
                    dds_start_d  = 1'b1;
                    pulse_done_d = ((cnt_q + 33'd1) == {1'b0, len_q});
                end
            end
            GAP: begin
                if (!run) begin
                    state_d = IDLE;
                end else if (cnt_q == gap_q) begin
                    state_d    = LOAD;
                    prof_idx_d = adv_idx;
                    load_en    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 33'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // Profile parameters are captured only on entry to LOAD so they are settled before the gate rises.
    always_comb begin
        freq_d  = freq_q;
        dfreq_d = dfreq_q;
        drate_d = drate_q;
        len_d   = len_q;
        if (load_en) begin
            freq_d  = rd_prof.freq;
            dfreq_d = rd_prof.delta_freq;
            drate_d = rd_prof.delta_rate;
            len_d   = pulse_len(rd_prof.len);
        end
    end

    // FSM state and every registered output; reset clears all of it, even mid-pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            prof_idx_q   <= '0;
            last_idx_q   <= '0;
            cnt_q        <= '0;
            gap_q        <= '0;
            len_q        <= '0;
            freq_q       <= '0;
            dfreq_q      <= '0;
            drate_q      <= '0;
            dds_start_q  <= 1'b0;
            pulse_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            prof_idx_q   <= prof_idx_d;
            last_idx_q   <= last_idx_d;
            cnt_q        <= cnt_d;
            gap_q        <= gap_d;
            len_q        <= len_d;
            freq_q       <= freq_d;
            dfreq_q      <= dfreq_d;
            drate_q      <= drate_d;
            dds_start_q  <= dds_start_d;
            pulse_done_q <= pulse_done_d;
            busy_q       <= busy_d;
        end
    end

    assign dds_freq       = freq_q;
    assign dds_delta_freq = dfreq_q;
    assign dds_delta_rate = drate_q;
    assign dds_start      = dds_start_q;
    assign prof_idx       = prof_idx_q;
    assign pulse_done     = pulse_done_q;
    assign busy           = busy_q;

endmodule
